// File: rtl/mmio_write_tracer.sv
// Snoops MMIO writes, filters them by an address window, timestamps them and
// buffers {time, addr, mask, data} records in a FIFO drained over valid/ready.
module mmio_write_tracer #(
   parameter int          DEPTH        = 16,
   parameter int          TS_W         = 16,
   parameter logic [29:0] WIN_BASE     = 30'h0,
   parameter logic [29:0] WIN_MASK     = 30'h0,
   parameter logic [29:0] TOHOST       = 30'h3FFFFFFF,
   parameter int          OVERWRITE    = 0,
   parameter int          HALT_ON_DONE = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [29:0]                i_mmio_addr,
   input  logic [31:0]                i_mmio_data,
   input  logic [3:0]                 i_mmio_mask,
   input  logic                       i_mmio_wren,
   input  logic                       i_clear,
   output logic                       o_rd_valid,
   input  logic                       i_rd_ready,
   output logic [TS_W-1:0]            o_rd_time,
   output logic [29:0]                o_rd_addr,
   output logic [3:0]                 o_rd_mask,
   output logic [31:0]                o_rd_data,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic [15:0]                o_drop_cnt,
   output logic                       o_done,
   output logic [31:0]                o_done_code,
   output logic                       o_state
);
   // Read port handshake: a record transfers on a rising clk edge where
   // o_rd_valid & i_rd_ready are both high; the head is held stable otherwise.

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

   state_t          state, state_nxt;
   logic [AW:0]     wr_ptr, rd_ptr, count;
   logic [TS_W-1:0] ts;
   logic            hit, tohost, push, pop, full, write, adv_rd, drop;

   logic [TS_W-1:0] mem_time [DEPTH];
   logic [29:0]     mem_addr [DEPTH];
   logic [3:0]      mem_mask [DEPTH];
   logic [31:0]     mem_data [DEPTH];

   always_comb begin
      state_nxt = state;
      hit       = ((i_mmio_addr ^ WIN_BASE) & WIN_MASK) == 30'h0;
      push      = i_mmio_wren && (state == RUN) && hit;
      tohost    = i_mmio_wren && (state == RUN) &&
                  (i_mmio_addr == TOHOST) && (i_mmio_mask == 4'hF);
      case (state)
         RUN:     if (tohost && (HALT_ON_DONE != 0)) state_nxt = DONE;
         DONE:    state_nxt = DONE;
         default: state_nxt = RUN;
      endcase
   end

   // Extra pointer bit keeps full (count==DEPTH) distinct from empty.
   assign count  = wr_ptr - rd_ptr;
   assign full   = (count == (AW+1)'(DEPTH));
   assign pop    = o_rd_valid && i_rd_ready;
   assign write  = push && (!full || pop || (OVERWRITE != 0));
   assign drop   = push && full && !pop;
   assign adv_rd = pop || (drop && (OVERWRITE != 0));

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         state       <= RUN;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         ts          <= '0;
         o_drop_cnt  <= '0;
         o_done      <= 1'b0;
         o_done_code <= '0;
      end else begin
         state <= state_nxt;
         ts    <= ts + TS_W'(1);
         if (write)  wr_ptr <= wr_ptr + (AW+1)'(1);
         if (adv_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
         if (drop && (o_drop_cnt != 16'hFFFF)) o_drop_cnt <= o_drop_cnt + 16'd1;
         if (tohost) begin
            o_done      <= 1'b1;
            o_done_code <= i_mmio_data;
         end
      end
   end

   // Storage needs no reset: the pointers alone decide what is visible.
   always_ff @(posedge clk) begin
      if (write) begin
         mem_time[wr_ptr[AW-1:0]] <= ts;
         mem_addr[wr_ptr[AW-1:0]] <= i_mmio_addr;
         mem_mask[wr_ptr[AW-1:0]] <= i_mmio_mask;
         mem_data[wr_ptr[AW-1:0]] <= i_mmio_data;
      end
   end

   assign o_rd_valid = (count != '0);
   assign o_count    = count;
   assign o_state    = (state == DONE);
   assign o_rd_time  = o_rd_valid ? mem_time[rd_ptr[AW-1:0]] : '0;
   assign o_rd_addr  = o_rd_valid ? mem_addr[rd_ptr[AW-1:0]] : '0;
   assign o_rd_mask  = o_rd_valid ? mem_mask[rd_ptr[AW-1:0]] : '0;
   assign o_rd_data  = o_rd_valid ? mem_data[rd_ptr[AW-1:0]] : '0;

endmodule

// File: tb/tb_mmio_write_tracer.sv
// Bench for mmio_write_tracer: three configurations share one stimulus stream
// and are compared every cycle against a queue-based reference model.
module tb_mmio_write_tracer;
  localparam int DEPTH = 8;
  localparam logic [29:0] TOHOST = 30'h3FFFFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1, clr = 1'b0, wren = 1'b0, ready = 1'b0;
  logic [29:0] addr = '0;
  logic [31:0] data = '0;
  logic [3:0]  mask = '0;

  logic [2:0]  rd_valid, done, state;
  logic [15:0] rd_time [3];
  logic [29:0] rd_addr [3];
  logic [3:0]  rd_mask [3];
  logic [31:0] rd_data [3];
  logic [3:0]  cnt [3];
  logic [15:0] drop [3];
  logic [31:0] code [3];

  int n_total = 0;
  int n_pass  = 0;

  // Per-instance configuration: 0 = drop-new/halt, 1 = overwrite/no-halt, 2 = windowed.
  logic [29:0] cfg_base [3];
  logic [29:0] cfg_wmask [3];
  logic        cfg_ovw [3];
  logic        cfg_halt [3];

  logic [81:0] mq [3][$];
  logic [15:0] mts [3];
  logic [15:0] mdrop [3];
  logic        mdone [3];
  logic [31:0] mcode [3];
  logic        mhalt [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mmio_write_tracer #(
      .DEPTH(DEPTH), .TS_W(16),
      .WIN_BASE(g == 2 ? 30'h100 : 30'h0),
      .WIN_MASK(g == 2 ? 30'h3FFFFF00 : 30'h0),
      .TOHOST(TOHOST),
      .OVERWRITE(g == 1 ? 1 : 0),
      .HALT_ON_DONE(g == 1 ? 0 : 1)
    ) u_dut (
      .clk(clk), .rst(rst),
      .i_mmio_addr(addr), .i_mmio_data(data), .i_mmio_mask(mask),
      .i_mmio_wren(wren), .i_clear(clr),
      .o_rd_valid(rd_valid[g]), .i_rd_ready(ready),
      .o_rd_time(rd_time[g]), .o_rd_addr(rd_addr[g]),
      .o_rd_mask(rd_mask[g]), .o_rd_data(rd_data[g]),
      .o_count(cnt[g]), .o_drop_cnt(drop[g]),
      .o_done(done[g]), .o_done_code(code[g]), .o_state(state[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: what one clock edge does to each instance, from the block's rules.
  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      if (rst || clr) begin
        mq[i].delete();
        mts[i] = '0; mdrop[i] = '0; mdone[i] = 1'b0; mcode[i] = '0; mhalt[i] = 1'b0;
      end else begin
        logic        hit, live;
        logic [81:0] rec;
        hit  = ((addr ^ cfg_base[i]) & cfg_wmask[i]) == 30'h0;
        live = wren && !mhalt[i];
        rec  = {mts[i], addr, mask, data};
        if (mq[i].size() > 0 && ready) void'(mq[i].pop_front());
        if (live && hit) begin
          if (mq[i].size() < DEPTH) mq[i].push_back(rec);
          else begin
            if (cfg_ovw[i]) begin
              void'(mq[i].pop_front());
              mq[i].push_back(rec);
            end
            if (mdrop[i] != 16'hFFFF) mdrop[i] = mdrop[i] + 16'd1;
          end
        end
        if (live && addr == TOHOST && mask == 4'hF) begin
          mdone[i] = 1'b1;
          mcode[i] = data;
          if (cfg_halt[i]) mhalt[i] = 1'b1;
        end
        mts[i] = mts[i] + 16'd1;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      logic [81:0] head;
      logic        hv;
      hv   = mq[i].size() != 0;
      head = hv ? mq[i][0] : '0;
      check($sformatf("u%0d valid", i), 64'(rd_valid[i]), 64'(hv));
      check($sformatf("u%0d count", i), 64'(cnt[i]), 64'(mq[i].size()));
      check($sformatf("u%0d time", i), 64'(rd_time[i]), 64'(head[81:66]));
      check($sformatf("u%0d addr", i), 64'(rd_addr[i]), 64'(head[65:36]));
      check($sformatf("u%0d mask", i), 64'(rd_mask[i]), 64'(head[35:32]));
      check($sformatf("u%0d data", i), 64'(rd_data[i]), 64'(head[31:0]));
      check($sformatf("u%0d drop", i), 64'(drop[i]), 64'(mdrop[i]));
      check($sformatf("u%0d done", i), 64'(done[i]), 64'(mdone[i]));
      check($sformatf("u%0d code", i), 64'(code[i]), 64'(mcode[i]));
      check($sformatf("u%0d state", i), 64'(state[i]), 64'(mhalt[i]));
    end
  endtask

  task automatic step(input logic r, input logic c, input logic w, input logic [29:0] a,
                      input logic [31:0] d, input logic [3:0] m, input logic rdy);
    @(negedge clk);
    rst = r; clr = c; wren = w; addr = a; data = d; mask = m; ready = rdy;
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, rdy);
  endtask

  initial begin
    cfg_base  = '{30'h0, 30'h0, 30'h100};
    cfg_wmask = '{30'h0, 30'h0, 30'h3FFFFF00};
    cfg_ovw   = '{1'b0, 1'b1, 1'b0};
    cfg_halt  = '{1'b1, 1'b0, 1'b1};

    // Reset, then a single write captured at ts=5
    step(1'b1, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0);
    check("reset valid", 64'(rd_valid[0]), 64'(0));
    idle(5, 1'b0);
    step(1'b0, 1'b0, 1'b1, 30'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    check("t1 time", 64'(rd_time[0]), 64'(5));
    check("t1 data", 64'(rd_data[0]), 64'hDEADBEEF);
    idle(2, 1'b0);
    idle(1, 1'b1);
    check("t1 pop count", 64'(cnt[0]), 64'(0));

    // Overflow with ready low: drop-new vs drop-oldest
    for (int k = 0; k < DEPTH + 3; k++)
      step(1'b0, 1'b0, 1'b1, 30'(30'h100 + k), 32'(k + 1), 4'hF, 1'b0);
    check("t2 count", 64'(cnt[0]), 64'(DEPTH));
    check("t2 drop u0", 64'(drop[0]), 64'(3));
    check("t3 drop u1", 64'(drop[1]), 64'(3));
    check("t2 head u0", 64'(rd_data[0]), 64'(1));
    check("t3 head u1", 64'(rd_data[1]), 64'(4));
    idle(DEPTH + 1, 1'b1);

    // Full FIFO, push and pop on the same edge
    for (int k = 0; k < DEPTH; k++)
      step(1'b0, 1'b0, 1'b1, 30'(30'h180 + k), 32'(32'h100 + k), 4'h3, 1'b0);
    step(1'b0, 1'b0, 1'b1, 30'h1F0, 32'hCAFE, 4'hF, 1'b1);
    check("t4 count", 64'(cnt[0]), 64'(DEPTH));
    check("t4 drop", 64'(drop[0]), 64'(3));
    idle(DEPTH + 1, 1'b1);

    // Address window
    step(1'b0, 1'b1, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 30'h1FF, 32'h11, 4'hF, 1'b0);
    step(1'b0, 1'b0, 1'b1, 30'h200, 32'h22, 4'hF, 1'b0);
    check("t5 u2 count", 64'(cnt[2]), 64'(1));
    check("t5 u0 count", 64'(cnt[0]), 64'(2));
    check("t5 u2 addr", 64'(rd_addr[2]), 64'h1FF);

    // Tohost ends the run; partial mask does not
    step(1'b0, 1'b1, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, TOHOST, 32'h7, 4'h3, 1'b0);
    check("t6 partial done", 64'(done[0]), 64'(0));
    step(1'b0, 1'b0, 1'b1, TOHOST, 32'h1, 4'hF, 1'b0);
    check("t6 done", 64'(done[0]), 64'(1));
    check("t6 code", 64'(code[0]), 64'(1));
    step(1'b0, 1'b0, 1'b1, 30'h20, 32'h5, 4'hF, 1'b0);
    check("t6 halted count", 64'(cnt[0]), 64'(2));
    step(1'b0, 1'b0, 1'b1, TOHOST, 32'h9, 4'hF, 1'b0);
    check("t6 u1 recode", 64'(code[1]), 64'(9));
    step(1'b0, 1'b1, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0);
    check("t6 clear done", 64'(done[0]), 64'(0));

    // Reset mid-burst
    for (int k = 0; k < 5; k++)
      step(1'b0, 1'b0, 1'b1, 30'(30'h140 + k), $urandom, 4'hF, 1'b0);
    step(1'b1, 1'b0, 1'b1, 30'h150, 32'h1234, 4'hF, 1'b0);
    check("t7 reset count", 64'(cnt[0]), 64'(0));

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      logic        r, c, w, rdy;
      logic [29:0] a;
      logic [3:0]  m;
      r   = ($urandom_range(0, 89) == 0);
      c   = ($urandom_range(0, 59) == 0);
      w   = ($urandom_range(0, 9) < 7);
      rdy = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 19) == 0) begin
        a = TOHOST;
        m = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 14));
      end else begin
        a = 30'($urandom_range(32'h0F0, 32'h21F));
        m = 4'($urandom_range(0, 15));
      end
      step(r, c, w, a, $urandom, m, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
